// File: rtl/mips_fetch_issue_unit_if.sv
// Fetch/issue bus: instruction-memory handshake toward memory, decoded fields
// and issue handshake toward the control unit and datapath.
interface mips_fetch_issue_unit_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [31:0]            IMemAddr;
  logic                   IMemReq;
  logic                   IMemValid;
  logic [31:0]            IMemData;
  logic [5:0]             Opcode;
  logic [4:0]             Rs, Rt, Rd;
  logic [15:0]            Imm16;
  logic                   InstrValid;
  logic                   Advance;
  logic                   Branch;
  logic                   Zero;
  logic [31:0]            PC;
  logic                   Illegal;
  logic [COUNT_WIDTH-1:0] InstrCount;

  modport master (
    output IMemAddr, IMemReq, Opcode, Rs, Rt, Rd, Imm16, InstrValid, PC, Illegal, InstrCount,
    input  IMemValid, IMemData, Advance, Branch, Zero
  );

  modport slave (
    input  IMemAddr, IMemReq, Opcode, Rs, Rt, Rd, Imm16, InstrValid, PC, Illegal, InstrCount,
    output IMemValid, IMemData, Advance, Branch, Zero
  );
endinterface

// File: rtl/mips_fetch_issue_unit.sv
// Fetch/issue front end: fetches a word into IR, issues it, and resolves
// sequential, beq and j next-PC on Advance; halts on undecodable opcodes.
module mips_fetch_issue_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input logic                     CLK,
  input logic                     Reset,
  mips_fetch_issue_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

  state_t                 state;
  logic [31:0]            pc, ir;
  logic                   req, vld, ill;
  logic [COUNT_WIDTH-1:0] cnt;

  logic [31:0] pc4, br_tgt, j_tgt, next_pc;
  logic        legal;

  always_comb begin
    pc4     = pc + 32'd4;
    br_tgt  = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    j_tgt   = {pc4[31:28], ir[25:0], 2'b00};
    next_pc = (ir[31:26] == 6'd2)        ? j_tgt  :
              (bus.Branch && bus.Zero)   ? br_tgt : pc4;
  end

  // Opcodes the downstream control unit decodes: R-type, j, beq, lw, sw.
  always_comb begin
    case (bus.IMemData[31:26])
      6'd0, 6'd2, 6'd4, 6'd35, 6'd43: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      req   <= 1'b0;
      vld   <= 1'b0;
      ill   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (bus.IMemValid) begin
            ir  <= bus.IMemData;
            req <= 1'b0;
            if (legal) begin
              state <= ISSUE;
              vld   <= 1'b1;
            end else begin
              state <= HALT;
              ill   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.Advance) begin
            pc    <= next_pc;
            cnt   <= cnt + COUNT_WIDTH'(1);
            vld   <= 1'b0;
            req   <= 1'b1;
            state <= REQ;
          end
        end
        default: ; // HALT: only Reset leaves
      endcase
    end
  end

  assign bus.IMemAddr   = pc;
  assign bus.IMemReq    = req;
  assign bus.Opcode     = ir[31:26];
  assign bus.Rs         = ir[25:21];
  assign bus.Rt         = ir[20:16];
  assign bus.Rd         = ir[15:11];
  assign bus.Imm16      = ir[15:0];
  assign bus.InstrValid = vld;
  assign bus.PC         = pc;
  assign bus.Illegal    = ill;
  assign bus.InstrCount = cnt;
endmodule

// File: tb/tb_mips_fetch_issue_unit.sv
// Directed + randomized bench for the fetch/issue unit with a reference PC model.
module tb_mips_fetch_issue_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_fetch_issue_unit_if #(.COUNT_WIDTH(CW)) bus ();

  mips_fetch_issue_unit #(.RESET_PC(32'h0000_0000), .COUNT_WIDTH(CW)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] m_ir;
  logic [31:0] w;
  logic [5:0]  ops [5] = '{6'd0, 6'd2, 6'd4, 6'd35, 6'd43};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  // Reference next-PC computed straight from the architectural rules.
  function automatic logic [31:0] ref_next(logic [31:0] pc, logic [31:0] ir, logic br, logic z);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (ir[31:26] == 6'd2) return (pc4 & 32'hF000_0000) | ({6'b0, ir[25:0]} * 32'd4);
    if (br && z)           return pc4 + 32'($signed(ir[15:0])) * 32'd4;
    return pc4;
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd35, 6'd43};
  endfunction

  task automatic fetch(input logic [31:0] word, input int lat);
    int waited = 0;
    while (!bus.IMemReq && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", 32'(bus.IMemReq), 32'd1);
    chk("imem_addr", bus.IMemAddr, m_pc);
    chk("ivalid_in_req", 32'(bus.InstrValid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      bus.Advance = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req_held", 32'(bus.IMemReq), 32'd1);
    end
    bus.Advance   = 1'b0;
    bus.IMemValid = 1'b1;
    bus.IMemData  = word;
    @(negedge clk);
    bus.IMemValid = 1'b0;
    bus.IMemData  = $urandom;
    m_ir = word;
    chk("req_dropped", 32'(bus.IMemReq), 32'd0);
    chk("pc_issue", bus.PC, m_pc);
    if (is_legal(word[31:26])) begin
      chk("ivalid", 32'(bus.InstrValid), 32'd1);
      chk("opcode", 32'(bus.Opcode), 32'(word[31:26]));
      chk("rs_rt_rd", {17'd0, bus.Rs, bus.Rt, bus.Rd}, {17'd0, word[25:11]});
      chk("imm16", 32'(bus.Imm16), 32'(word[15:0]));
      chk("count_issue", 32'(bus.InstrCount), 32'(m_cnt % (1 << CW)));
    end else begin
      chk("illegal_set", 32'(bus.Illegal), 32'd1);
      chk("ivalid_halt", 32'(bus.InstrValid), 32'd0);
    end
  endtask

  task automatic advance(input logic br, input logic z, input int stall);
    for (int i = 0; i < stall; i++) begin
      bus.Advance   = 1'b0;
      bus.IMemValid = 1'($urandom_range(0, 1));
      bus.IMemData  = $urandom;
      @(negedge clk);
      bus.IMemValid = 1'b0;
      chk("stall_ivalid", 32'(bus.InstrValid), 32'd1);
      chk("stall_noreq", 32'(bus.IMemReq), 32'd0);
      chk("stall_ir", {bus.Opcode, bus.Rs, bus.Rt, bus.Imm16}, m_ir);
      chk("stall_pc", bus.PC, m_pc);
    end
    bus.Advance = 1'b1;
    bus.Branch  = br;
    bus.Zero    = z;
    @(negedge clk);
    bus.Advance = 1'b0;
    bus.Branch  = 1'($urandom_range(0, 1));
    bus.Zero    = 1'($urandom_range(0, 1));
    m_pc = ref_next(m_pc, m_ir, br, z);
    m_cnt++;
    chk("adv_ivalid", 32'(bus.InstrValid), 32'd0);
    chk("adv_req", 32'(bus.IMemReq), 32'd1);
    chk("adv_pc", bus.IMemAddr, m_pc);
    chk("adv_count", 32'(bus.InstrCount), 32'(m_cnt % (1 << CW)));
  endtask

  function automatic logic [31:0] mk(logic [5:0] op, logic [15:0] imm);
    return {op, 5'($urandom), 5'($urandom), imm};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.IMemValid = 1'b0;
    bus.IMemData  = '0;
    bus.Advance   = 1'b0;
    bus.Branch    = 1'b0;
    bus.Zero      = 1'b0;
    m_pc = 32'h0; m_cnt = 0; m_ir = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req", 32'(bus.IMemReq), 32'd0);
    chk("rst_ivalid", 32'(bus.InstrValid), 32'd0);
    chk("rst_illegal", 32'(bus.Illegal), 32'd0);
    chk("rst_count", 32'(bus.InstrCount), 32'd0);
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_ir", {bus.Opcode, bus.Rs, bus.Rt, bus.Imm16}, 32'h0);
    rst = 1'b0;

    // Sequential fetch, 2-cycle latency
    fetch(mk(6'd0, 16'($urandom)), 2); advance(1'b0, 1'b0, 0);
    fetch(mk(6'd0, 16'($urandom)), 2); advance(1'b0, 1'b1, 0);
    // Jump to 0x10, beq taken back to 0x0C, jump to 0x10, beq not taken
    fetch({6'd2, 26'h4}, 1);             advance(1'b0, 1'b0, 0);
    fetch(mk(6'd4, 16'hFFFE), 0);        advance(1'b1, 1'b1, 0);
    chk("beq_taken", m_pc, 32'h0000_000C);
    fetch({6'd2, 26'h4}, 0);             advance(1'b1, 1'b1, 0);
    fetch(mk(6'd4, 16'hFFFE), 3);        advance(1'b1, 1'b0, 0);
    chk("beq_not_taken", m_pc, 32'h0000_0014);
    // Jump to 0x100 twice
    fetch({6'd2, 26'h40}, 0);            advance(1'b0, 1'b0, 0);
    fetch({6'd2, 26'h40}, 1);            advance(1'b1, 1'b1, 0);
    chk("jump_self", m_pc, 32'h0000_0100);
    // Stall with stray IMemValid pulses
    fetch(mk(6'd35, 16'($urandom)), 0);  advance(1'b0, 1'b0, 5);
    // Backward branch below zero, then PC wrap
    fetch(mk(6'd4, 16'hFFBD), 0);        advance(1'b1, 1'b1, 0);
    chk("pc_neg", m_pc, 32'hFFFF_FFFC);
    fetch(mk(6'd43, 16'($urandom)), 1);  advance(1'b0, 1'b0, 0);
    chk("pc_wrap", m_pc, 32'h0);

    // Randomized legal stream; InstrCount wraps at 16
    for (int n = 0; n < 24; n++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 4)];
      fetch(w, int'($urandom_range(0, 3)));
      advance(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    // Illegal opcode -> HALT, deaf to Advance and IMemValid
    w = $urandom;
    w[31:26] = 6'h3F;
    fetch(w, 1);
    for (int i = 0; i < 6; i++) begin
      bus.Advance   = 1'b1;
      bus.IMemValid = 1'b1;
      bus.IMemData  = 32'h0000_0000;
      @(negedge clk);
      chk("halt_illegal", 32'(bus.Illegal), 32'd1);
      chk("halt_req", 32'(bus.IMemReq), 32'd0);
      chk("halt_ivalid", 32'(bus.InstrValid), 32'd0);
      chk("halt_pc", bus.PC, m_pc);
      chk("halt_ir", {bus.Opcode, bus.Rs, bus.Rt, bus.Imm16}, w);
      chk("halt_count", 32'(bus.InstrCount), 32'(m_cnt % (1 << CW)));
    end
    bus.Advance = 1'b0;
    bus.IMemValid = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt_rst_illegal", 32'(bus.Illegal), 32'd0);
    chk("halt_rst_pc", bus.PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_cnt = 0;

    // Reset asserted mid-REQ, between edges
    fetch(mk(6'd0, 16'($urandom)), 0);   advance(1'b0, 1'b0, 0);
    chk("pre_rst_count", 32'(bus.InstrCount), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_req", 32'(bus.IMemReq), 32'd0);
    chk("async_ivalid", 32'(bus.InstrValid), 32'd0);
    chk("async_count", 32'(bus.InstrCount), 32'd0);
    chk("async_pc", bus.PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_cnt = 0;
    @(negedge clk);
    chk("restart_req", 32'(bus.IMemReq), 32'd1);
    chk("restart_addr", bus.IMemAddr, 32'h0);
    fetch(mk(6'd43, 16'($urandom)), 2);  advance(1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
